// File: rtl/atp_pkg.sv
// Shared definitions for the ATP responder: op codes, FSM states, the op request
// record and the power-on contents of the account table.
package atp_pkg;

    localparam int NUM_ACC = 4;
    localparam int BAL_W   = 12;
    localparam int IDX_W   = $clog2(NUM_ACC);

    localparam logic [2:0] OP_BILL_PAYMENT   = 3'b010;
    localparam logic [2:0] OP_CHARGES        = 3'b011;
    localparam logic [2:0] OP_PAYMENT_METHOD = 3'b100;
    localparam logic [2:0] OP_OLD_BALANCE    = 3'b101;
    localparam logic [2:0] OP_TRANSACTION    = 3'b110;
    localparam logic [2:0] OP_RECEIPT        = 3'b111;

    localparam logic METHOD_CASH   = 1'b0;
    localparam logic METHOD_CHEQUE = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE, ST_LOOKUP, ST_AUTH, ST_SESSION, ST_EXEC, ST_LOCKED
    } state_t;

    typedef struct packed {
        logic [2:0]  op;
        logic [10:0] amount;
        logic [11:0] dest;
    } op_req_t;

    // Entry 0 sits in the least significant slice.
    localparam logic [NUM_ACC-1:0][11:0]      INIT_PHONE = {12'd4321, 12'd1234, 12'd2816, 12'd2178};
    localparam logic [NUM_ACC-1:0][3:0]       INIT_PIN   = {4'b1111, 4'b0001, 4'b0110, 4'b0100};
    localparam logic [NUM_ACC-1:0][BAL_W-1:0] INIT_BAL   = {12'd4000, 12'd0, 12'd500, 12'd2000};
    localparam logic [NUM_ACC-1:0][BAL_W-1:0] INIT_DUE   = {12'd0, 12'd50, 12'd120, 12'd300};

endpackage

// File: rtl/atp_account_lookup.sv
// Combinational phone-number match over the fixed account directory.
module atp_account_lookup
    import atp_pkg::*;
(
    input  logic [11:0]      phone,
    output logic             hit,
    output logic [IDX_W-1:0] idx
);

    // Descending scan so the lowest matching entry wins.
    always_comb begin
        hit = 1'b0;
        idx = '0;
        for (int i = NUM_ACC - 1; i >= 0; i--) begin
            if (INIT_PHONE[i] == phone) begin
                hit = 1'b1;
                idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/atp_controller.sv
// ATP terminal responder: login/lockout FSM plus single-cycle execution of
// account operations against the on-chip balance/due table.
module atp_controller
    import atp_pkg::*;
#(
    parameter int CASH_LIMIT = 2000,
    parameter int MAX_TRIES  = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             exit,
    input  logic             login_valid,
    input  logic [11:0]      phone_number,
    input  logic [3:0]       pin,
    input  logic             op_valid,
    input  logic [2:0]       op,
    input  logic [10:0]      amount,
    input  logic [11:0]      dest_consumer,
    output logic             logged_in,
    output logic             locked,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [BAL_W-1:0] charges
);

    localparam int FC_W = $clog2(MAX_TRIES + 1);

    state_t                          state;
    logic [11:0]                     phone_r;
    logic [3:0]                      pin_r;
    logic                            hit_r;
    logic [IDX_W-1:0]                hit_idx_r, self_r;
    logic [FC_W-1:0]                 fail_cnt;
    logic                            method;
    logic [BAL_W-1:0]                last_txn;
    op_req_t                         req;
    logic [NUM_ACC-1:0][BAL_W-1:0]   bal, due;

    logic             lu_hit, d_hit;
    logic [IDX_W-1:0] lu_idx, d_idx;

    atp_account_lookup u_login_lu (.phone(phone_r),  .hit(lu_hit), .idx(lu_idx));
    atp_account_lookup u_dest_lu  (.phone(req.dest), .hit(d_hit),  .idx(d_idx));

    logic [BAL_W-1:0] amt, s_bal, s_due, d_bal;
    logic [BAL_W:0]   d_sum;
    logic             cash_viol, ex_ok;

    // All checks compare before anything is subtracted, so no underflow path exists.
    always_comb begin
        amt       = BAL_W'(req.amount);
        s_bal     = bal[self_r];
        s_due     = due[self_r];
        d_bal     = bal[d_idx];
        d_sum     = {1'b0, d_bal} + {1'b0, amt};
        cash_viol = (method == METHOD_CASH) && (amt > BAL_W'(CASH_LIMIT));
        ex_ok     = 1'b0;
        case (req.op)
            OP_BILL_PAYMENT: ex_ok = (amt <= s_bal) && (amt <= s_due) && !cash_viol;
            OP_TRANSACTION:  ex_ok = d_hit && (d_idx != self_r) && (amt <= s_bal)
                                     && !cash_viol && !d_sum[BAL_W];
            OP_CHARGES, OP_PAYMENT_METHOD,
            OP_OLD_BALANCE, OP_RECEIPT: ex_ok = 1'b1;
            default:         ex_ok = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            logged_in <= 1'b0;
            locked    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            charges   <= '0;
            phone_r   <= '0;
            pin_r     <= '0;
            hit_r     <= 1'b0;
            hit_idx_r <= '0;
            self_r    <= '0;
            fail_cnt  <= '0;
            method    <= METHOD_CASH;
            last_txn  <= '0;
            req       <= '0;
            bal       <= INIT_BAL;
            due       <= INIT_DUE;
        end else begin
            done  <= 1'b0;
            error <= 1'b0;
            // EXEC handles exit itself so the pending operation still commits.
            if (exit && state != ST_EXEC) begin
                state     <= ST_IDLE;
                logged_in <= 1'b0;
                locked    <= 1'b0;
                busy      <= 1'b0;
                method    <= METHOD_CASH;
                if (state == ST_LOCKED) fail_cnt <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (login_valid) begin
                            phone_r <= phone_number;
                            pin_r   <= pin;
                            busy    <= 1'b1;
                            state   <= ST_LOOKUP;
                        end else if (op_valid) begin
                            error <= 1'b1;
                        end
                    end
                    ST_LOOKUP: begin
                        hit_r     <= lu_hit;
                        hit_idx_r <= lu_idx;
                        state     <= ST_AUTH;
                    end
                    ST_AUTH: begin
                        busy <= 1'b0;
                        if (hit_r && pin_r == INIT_PIN[hit_idx_r]) begin
                            self_r    <= hit_idx_r;
                            logged_in <= 1'b1;
                            done      <= 1'b1;
                            fail_cnt  <= '0;
                            state     <= ST_SESSION;
                        end else begin
                            error    <= 1'b1;
                            fail_cnt <= fail_cnt + 1'b1;
                            if (fail_cnt == FC_W'(MAX_TRIES - 1)) begin
                                locked <= 1'b1;
                                state  <= ST_LOCKED;
                            end else begin
                                state  <= ST_IDLE;
                            end
                        end
                    end
                    ST_SESSION: begin
                        if (op_valid) begin
                            req   <= {op, amount, dest_consumer};
                            busy  <= 1'b1;
                            state <= ST_EXEC;
                        end
                    end
                    ST_EXEC: begin
                        busy  <= 1'b0;
                        done  <= ex_ok;
                        error <= !ex_ok;
                        if (ex_ok) begin
                            case (req.op)
                                OP_BILL_PAYMENT: begin
                                    bal[self_r] <= s_bal - amt;
                                    due[self_r] <= s_due - amt;
                                    last_txn    <= amt;
                                    charges     <= s_due - amt;
                                end
                                OP_TRANSACTION: begin
                                    bal[self_r] <= s_bal - amt;
                                    bal[d_idx]  <= d_sum[BAL_W-1:0];
                                    last_txn    <= amt;
                                    charges     <= s_bal - amt;
                                end
                                OP_CHARGES:        charges <= s_due;
                                OP_OLD_BALANCE:    charges <= s_bal;
                                OP_RECEIPT:        charges <= last_txn;
                                OP_PAYMENT_METHOD: method  <= req.amount[0];
                                default: ;
                            endcase
                        end
                        if (exit) begin
                            logged_in <= 1'b0;
                            method    <= METHOD_CASH;
                            state     <= ST_IDLE;
                        end else begin
                            state     <= ST_SESSION;
                        end
                    end
                    ST_LOCKED: begin
                        if (login_valid || op_valid) error <= 1'b1;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_atp_controller.sv
// Directed and randomized checks of atp_controller against a transaction-level
// account model (balances, dues, session flags) held in the bench.
module tb_atp_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        exit = 1'b0;
    logic        login_valid = 1'b0;
    logic [11:0] phone_number = '0;
    logic [3:0]  pin = '0;
    logic        op_valid = 1'b0;
    logic [2:0]  op = '0;
    logic [10:0] amount = '0;
    logic [11:0] dest_consumer = '0;
    logic        logged_in, locked, busy, done, error;
    logic [11:0] charges;

    atp_controller dut (
        .clk(clk), .rst(rst), .exit(exit), .login_valid(login_valid),
        .phone_number(phone_number), .pin(pin), .op_valid(op_valid), .op(op),
        .amount(amount), .dest_consumer(dest_consumer), .logged_in(logged_in),
        .locked(locked), .busy(busy), .done(done), .error(error), .charges(charges)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    // Reference model: the account table and session as plain integers.
    int m_phone[4] = '{2178, 2816, 1234, 4321};
    int m_pin[4]   = '{4, 6, 1, 15};
    int m_bal[4], m_due[4];
    bit m_logged, m_locked;
    int m_self, m_fails, m_method, m_last, m_charges;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int find(input int ph);
        for (int i = 0; i < 4; i++) if (m_phone[i] == ph) return i;
        return -1;
    endfunction

    task automatic model_reset();
        m_bal = '{2000, 500, 0, 4000};
        m_due = '{300, 120, 50, 0};
        m_logged = 0; m_locked = 0;
        m_self = 0; m_fails = 0; m_method = 0; m_last = 0; m_charges = 0;
    endtask

    task automatic model_exec(input int o, input int a, input int dph, output bit ok);
        int d;
        bit cash;
        cash = (m_method == 0) && (a > 2000);
        d = find(dph);
        ok = 0;
        case (o)
            2: if (a <= m_bal[m_self] && a <= m_due[m_self] && !cash) begin
                   ok = 1;
                   m_bal[m_self] -= a; m_due[m_self] -= a;
                   m_last = a; m_charges = m_due[m_self];
               end
            3: begin ok = 1; m_charges = m_due[m_self]; end
            4: begin ok = 1; m_method = a % 2; end
            5: begin ok = 1; m_charges = m_bal[m_self]; end
            6: if (d >= 0 && d != m_self && a <= m_bal[m_self] && !cash && m_bal[d] + a <= 4095) begin
                   ok = 1;
                   m_bal[m_self] -= a; m_bal[d] += a;
                   m_last = a; m_charges = m_bal[m_self];
               end
            7: begin ok = 1; m_charges = m_last; end
            default: ok = 0;
        endcase
    endtask

    // Strobes were raised at the previous negedge; observe ncyc cycles after the sampling edge.
    task automatic window(input string tag, input int ncyc, input int pcyc, input bit exp_ok,
                          input int busy_mask);
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            if (c == 1) begin login_valid = 0; op_valid = 0; exit = 0; end
            chk($sformatf("%s.done@%0d", tag, c), 32'(done), 32'(c == pcyc && exp_ok));
            chk($sformatf("%s.error@%0d", tag, c), 32'(error), 32'(c == pcyc && !exp_ok));
            chk($sformatf("%s.busy@%0d", tag, c), 32'(busy), 32'((busy_mask >> (c - 1)) & 1));
        end
        chk({tag, ".charges"}, 32'(charges), 32'(m_charges));
        chk({tag, ".logged_in"}, 32'(logged_in), 32'(m_logged));
        chk({tag, ".locked"}, 32'(locked), 32'(m_locked));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1; exit = 0; login_valid = 0; op_valid = 0;
        @(negedge clk);
        @(negedge clk);
        chk("rst.charges", 32'(charges), 0);
        chk("rst.flags", 32'({logged_in, locked, busy, done, error}), 0);
        rst = 0;
        model_reset();
    endtask

    task automatic do_login(input int ph, input int pn);
        int idx;
        bit ok;
        @(negedge clk);
        login_valid = 1; phone_number = 12'(ph); pin = 4'(pn);
        if (m_locked) window("login_locked", 1, 1, 0, 0);
        else if (m_logged) window("login_ignored", 3, 0, 0, 0);
        else begin
            idx = find(ph);
            ok = (idx >= 0) && (m_pin[idx] == pn);
            if (ok) begin m_logged = 1; m_self = idx; m_fails = 0; end
            else begin m_fails++; if (m_fails >= 3) m_locked = 1; end
            window("login", 3, 3, ok, 3);
        end
    endtask

    task automatic do_op(input int o, input int a, input int dph);
        bit ok;
        @(negedge clk);
        op_valid = 1; op = 3'(o); amount = 11'(a); dest_consumer = 12'(dph);
        if (!m_logged) window("op_nosess", 1, 1, 0, 0);
        else begin
            model_exec(o, a, dph, ok);
            window($sformatf("op%0d", o), 2, 2, ok, 1);
        end
    endtask

    task automatic do_exit();
        @(negedge clk);
        exit = 1;
        m_logged = 0; m_method = 0;
        if (m_locked) begin m_locked = 0; m_fails = 0; end
        window("exit", 1, 0, 0, 0);
    endtask

    initial begin
        bit ok;
        int r, ph, pn;
        model_reset();
        do_reset();

        // Login, bad phone, charges/bill payment/balance.
        do_login(2178, 4);
        do_exit();
        do_login(2278, 4);
        chk("fails_after_bad", 32'(m_fails), 1);
        do_login(2178, 4);
        do_op(3, 0, 0);
        chk("charges_init_due", 32'(charges), 300);
        do_op(2, 100, 0);
        chk("bill100_due", 32'(charges), 200);
        do_op(5, 0, 0);
        chk("bal_after_bill", 32'(charges), 1900);
        do_op(2, 2047, 0);
        do_op(5, 0, 0);
        chk("bal_after_bad_bill", 32'(charges), 1900);
        do_op(4, 0, 0);
        do_op(2, 200, 0);
        do_op(2, 0, 0);

        // Transfers and their rejection cases.
        do_op(6, 50, 2816);
        do_op(6, 2047, 2816);
        do_op(6, 10, 9999);
        do_op(6, 10, 2178);
        do_op(7, 0, 0);
        chk("receipt50", 32'(charges), 50);
        do_op(1, 5, 0);
        do_op(0, 5, 0);
        do_op(6, 96, 4321);
        do_op(6, 95, 4321);

        // Cash limit versus cheque.
        do_exit();
        do_login(4321, 15);
        do_op(4, 0, 0);
        do_op(6, 2001, 1234);
        do_op(4, 1, 0);
        do_op(6, 2001, 1234);
        do_exit();
        do_login(2816, 6);
        do_op(5, 0, 0);
        chk("dest_credited", 32'(charges), 550);

        // Lockout and release.
        do_exit();
        repeat (3) do_login(9999, 0);
        chk("locked_after_3", 32'(locked), 1);
        do_login(2178, 4);
        do_op(3, 0, 0);
        do_exit();
        do_login(2178, 4);

        // exit together with op_valid: strobe dropped.
        @(negedge clk);
        exit = 1; op_valid = 1; op = 3'd3;
        m_logged = 0; m_method = 0;
        window("exit_op", 2, 0, 0, 0);

        // exit during EXEC: the op still completes.
        do_login(2178, 4);
        @(negedge clk);
        op_valid = 1; op = 3'd5;
        model_exec(5, 0, 0, ok);
        m_logged = 0; m_method = 0;
        @(negedge clk);
        op_valid = 0; exit = 1;
        @(negedge clk);
        exit = 0;
        chk("exit_exec.done", 32'(done), 1);
        chk("exit_exec.charges", 32'(charges), 32'(m_charges));
        chk("exit_exec.logged_in", 32'(logged_in), 0);

        // rst during EXEC discards the pending write.
        do_login(2178, 4);
        @(negedge clk);
        op_valid = 1; op = 3'd2; amount = 11'd100;
        @(negedge clk);
        op_valid = 0; rst = 1;
        @(negedge clk);
        chk("rst_exec.flags", 32'({logged_in, locked, busy, done, error}), 0);
        chk("rst_exec.charges", 32'(charges), 0);
        rst = 0;
        model_reset();
        do_login(2178, 4);
        do_op(5, 0, 0);
        chk("rst_exec.bal_init", 32'(charges), 2000);

        // Randomized traffic against the model.
        for (int it = 0; it < 400; it++) begin
            r = $urandom_range(0, 99);
            if (r < 8) do_exit();
            else if (r < 30) begin
                ph = ($urandom_range(0, 3) != 0) ? m_phone[$urandom_range(0, 3)] : $urandom_range(0, 4095);
                pn = $urandom_range(0, 15);
                if ($urandom_range(0, 9) < 7 && find(ph) >= 0) pn = m_pin[find(ph)];
                do_login(ph, pn);
            end else begin
                ph = ($urandom_range(0, 4) != 0) ? m_phone[$urandom_range(0, 3)] : $urandom_range(0, 4095);
                do_op($urandom_range(0, 7),
                      ($urandom_range(0, 1) != 0) ? $urandom_range(0, 300) : $urandom_range(0, 2047), ph);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
